// File: rtl/dcache_linefill_if.sv
// Interfaces of the data-cache line filler: the cache memory port and the
// 32-bit system bus port.

interface dcache_mem_if;
   logic         mem_request;
   logic         mem_rwn;
   logic [15:0]  mem_addr;
   logic [15:0]  mem_commit;
   logic [127:0] mem_write_data;
   logic         mem_finish;
   logic         mem_partial;
   logic         mem_replace;
   logic [4:0]   mem_replace_set;
   logic [6:0]   mem_replace_tag;
   logic [127:0] mem_replace_dat;

   // master = data cache, slave = line filler
   modport master (
      output mem_request, mem_rwn, mem_addr, mem_commit, mem_write_data,
      input  mem_finish, mem_partial, mem_replace,
             mem_replace_set, mem_replace_tag, mem_replace_dat
   );
   modport slave (
      input  mem_request, mem_rwn, mem_addr, mem_commit, mem_write_data,
      output mem_finish, mem_partial, mem_replace,
             mem_replace_set, mem_replace_tag, mem_replace_dat
   );
endinterface

interface dcache_bus_if;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   // master = line filler, slave = system bus
   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_ack, bus_err, bus_rdata
   );
   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_ack, bus_err, bus_rdata
   );
endinterface

// File: rtl/dcache_linefill.sv
// Line filler between the data cache and the 32-bit bus: splits a 128-bit
// write-back into four bus writes, or fetches four words, merges commit bytes and replaces.

module dcache_linefill #(
   parameter int TIMEOUT = 255
) (
   input logic          sys_clk,
   input logic          sys_rst,
   dcache_mem_if.slave  mem,
   dcache_bus_if.master bus
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_t;

   localparam int              WCW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit              TMO_EN    = (TIMEOUT != 0);
   localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);

   state_t         state, state_nxt;
   logic [1:0]     beat_q, beat_nxt;
   logic [WCW-1:0] wait_q, wait_nxt;
   logic           err_q, err_nxt;
   logic [127:0]   line_q, line_nxt;
   logic [127:0]   merged;
   logic           capture, load_rep;
   logic           tmo, beat_done, beat_fail;

   logic [15:4]    addr_q;
   logic           rwn_q;
   logic [15:0]    commit_q;
   logic [127:0]   wdata_q;
   logic [4:0]     rep_set;
   logic [6:0]     rep_tag;
   logic [127:0]   rep_dat;

   logic           unused_addr_bits;
   assign unused_addr_bits = ^mem.mem_addr[3:0];

   // A beat ends on an ack or when its wait budget runs out; the latter counts as an error.
   assign tmo       = TMO_EN && !bus.bus_ack && (wait_q == WAIT_LAST);
   assign beat_done = bus.bus_ack || tmo;
   assign beat_fail = (bus.bus_ack && bus.bus_err) || tmo;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_nxt = state;
      beat_nxt  = beat_q;
      wait_nxt  = wait_q;
      err_nxt   = err_q;
      line_nxt  = line_q;
      capture   = 1'b0;
      load_rep  = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem.mem_request) begin
               capture   = 1'b1;
               beat_nxt  = 2'd0;
               wait_nxt  = '0;
               err_nxt   = 1'b0;
               line_nxt  = '0;
               state_nxt = mem.mem_rwn ? READ : WRITE;
            end
         end
         WRITE, READ: begin
            if (beat_done) begin
               wait_nxt = '0;
               if (state == READ && !beat_fail)
                  line_nxt[{beat_q, 5'b0} +: 32] = bus.bus_rdata;
               // Read errors abort the fill; write errors only skip the beat.
               if (state == READ && beat_fail) begin
                  err_nxt   = 1'b1;
                  state_nxt = FIN;
               end else if (beat_q == 2'd3) begin
                  state_nxt = FIN;
               end else begin
                  beat_nxt = beat_q + 2'd1;
               end
               load_rep = (state == READ) && (state_nxt == FIN);
            end else begin
               wait_nxt = wait_q + 1'b1;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      merged = line_nxt;
      for (int b = 0; b < 16; b++)
         if (commit_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state  <= IDLE;
         beat_q <= 2'd0;
         wait_q <= '0;
         err_q  <= 1'b0;
         line_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state  <= state_nxt;
         beat_q <= beat_nxt;
         wait_q <= wait_nxt;
         err_q  <= err_nxt;
         line_q <= line_nxt;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         addr_q   <= '0;
         rwn_q    <= 1'b0;
         commit_q <= '0;
         wdata_q  <= '0;
         rep_set  <= '0;
         rep_tag  <= '0;
         rep_dat  <= '0;
      end else begin
         if (capture) begin
            addr_q   <= mem.mem_addr[15:4];
            rwn_q    <= mem.mem_rwn;
            commit_q <= mem.mem_commit;
            wdata_q  <= mem.mem_write_data;
         end
         if (load_rep) begin
            rep_set <= addr_q[8:4];
            rep_tag <= addr_q[15:9];
            rep_dat <= merged;
         end
      end
   end

   assign bus.bus_req   = (state == WRITE) || (state == READ);
   assign bus.bus_we    = (state == WRITE);
   assign bus.bus_addr  = {addr_q, beat_q, 2'b00};
   assign bus.bus_wdata = wdata_q[{beat_q, 5'b0} +: 32];

   assign mem.mem_finish      = (state == FIN);
   assign mem.mem_replace     = (state == FIN) && rwn_q;
   assign mem.mem_partial     = (state == FIN) && rwn_q && err_q;
   assign mem.mem_replace_set = rep_set;
   assign mem.mem_replace_tag = rep_tag;
   assign mem.mem_replace_dat = rep_dat;

endmodule

// File: tb/tb_dcache_linefill.sv
// Directed bench for dcache_linefill: a small bus responder with configurable
// waits, errors and stalls, plus per-scenario tasks with hand-computed expectations.

module tb_dcache_linefill;

   localparam int TO = 4;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;
   always #5 sys_clk = ~sys_clk;

   dcache_mem_if mem_if ();
   dcache_bus_if bus_if ();

   dcache_linefill #(.TIMEOUT(TO)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .mem     (mem_if),
      .bus     (bus_if)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int t_edge = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // bus responder configuration
   int          wait_cfg   = 0;
   int          err_word   = -1;
   int          stall_word = -1;
   logic [31:0] rd_words [4];

   // bus responder log
   int          wcnt       = 0;
   int          nbeats     = 0;
   int          req_cycles = 0;
   logic [15:0] lg_addr  [64];
   logic        lg_we    [64];
   logic [31:0] lg_wdata [64];
   int          lg_cyc   [64];

   always @(negedge sys_clk) begin
      if (bus_if.bus_req === 1'b1) begin
         req_cycles++;
         if (wcnt < wait_cfg || int'(bus_if.bus_addr[3:2]) == stall_word) begin
            bus_if.bus_ack = 1'b0;
            bus_if.bus_err = 1'b0;
            wcnt++;
         end else begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_err   = (int'(bus_if.bus_addr[3:2]) == err_word);
            bus_if.bus_rdata = rd_words[bus_if.bus_addr[3:2]];
            if (nbeats < 64) begin
               lg_addr[nbeats]  = bus_if.bus_addr;
               lg_we[nbeats]    = bus_if.bus_we;
               lg_wdata[nbeats] = bus_if.bus_wdata;
               lg_cyc[nbeats]   = cyc;
            end
            nbeats++;
            wcnt = 0;
         end
      end else begin
         bus_if.bus_ack   = 1'b0;
         bus_if.bus_err   = 1'b0;
         bus_if.bus_rdata = 32'h0;
         wcnt = 0;
      end
   end

   // finish / replace monitor
   int           fin_count = 0;
   int           fin_cyc   = 0;
   int           dbl_fin   = 0;
   int           rep_stray = 0;
   logic         fin_prev  = 1'b0;
   logic         cap_replace, cap_partial;
   logic [4:0]   cap_set;
   logic [6:0]   cap_tag;
   logic [127:0] cap_dat;

   always @(negedge sys_clk) begin
      if (mem_if.mem_finish === 1'b1) begin
         fin_count++;
         fin_cyc     = cyc;
         cap_replace = mem_if.mem_replace;
         cap_partial = mem_if.mem_partial;
         cap_set     = mem_if.mem_replace_set;
         cap_tag     = mem_if.mem_replace_tag;
         cap_dat     = mem_if.mem_replace_dat;
         if (fin_prev) dbl_fin++;
      end else if (mem_if.mem_replace === 1'b1) begin
         rep_stray++;
      end
      fin_prev = (mem_if.mem_finish === 1'b1);
   end

   task automatic start_req(input logic rwn, input logic [15:0] addr,
                            input logic [15:0] commit, input logic [127:0] wd);
      @(negedge sys_clk);
      mem_if.mem_rwn        = rwn;
      mem_if.mem_addr       = addr;
      mem_if.mem_commit     = commit;
      mem_if.mem_write_data = wd;
      mem_if.mem_request    = 1'b1;
      t_edge = cyc + 1;
   endtask

   task automatic wait_fin(input int base, input string name, input bit drop);
      int n = 0;
      do begin
         @(negedge sys_clk);
         #1;
         n++;
      end while (fin_count == base && n < 80);
      if (drop) mem_if.mem_request = 1'b0;
      checks++;
      if (fin_count == base) begin
         errors++;
         $display("FAIL %s_finish: no mem_finish after %0d cycles", name, n);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge sys_clk);
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus_if.bus_req); end
      checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we: got %b want 0", bus_if.bus_we); end
      checks++; if (bus_if.bus_addr !== 16'h0) begin errors++; $display("FAIL rst_bus_addr: got %h want 0", bus_if.bus_addr); end
      checks++; if (bus_if.bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_bus_wdata: got %h want 0", bus_if.bus_wdata); end
      checks++; if (mem_if.mem_finish !== 1'b0 || mem_if.mem_replace !== 1'b0 || mem_if.mem_partial !== 1'b0) begin
         errors++; $display("FAIL rst_mem_flags: got %b%b%b want 000", mem_if.mem_finish, mem_if.mem_replace, mem_if.mem_partial);
      end
      checks++; if (mem_if.mem_replace_dat !== 128'h0 || mem_if.mem_replace_set !== 5'h0 || mem_if.mem_replace_tag !== 7'h0) begin
         errors++; $display("FAIL rst_replace_fields: got %h/%h/%h want zeros", mem_if.mem_replace_set, mem_if.mem_replace_tag, mem_if.mem_replace_dat);
      end
      sys_rst = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_alloc_basic;
      int b = nbeats;
      int f = fin_count;
      logic [15:0] ea;
      wait_cfg = 0; err_word = -1; stall_word = -1;
      rd_words = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
      start_req(1'b1, 16'h1230, 16'h0000, {4{32'h55555555}});
      wait_fin(f, "alloc", 1'b1);
      checks++; if (nbeats - b != 4) begin errors++; $display("FAIL alloc_beats: got %0d want 4", nbeats - b); end
      ea = 16'h1230;
      for (int k = 0; k < 4; k++) begin
         checks++; if (lg_addr[b+k] !== ea || lg_we[b+k] !== 1'b0) begin
            errors++; $display("FAIL alloc_addr%0d: got %h we=%b want %h we=0", k, lg_addr[b+k], lg_we[b+k], ea);
         end
         ea = ea + 16'd4;
      end
      checks++; if (fin_cyc - t_edge + 1 != 5) begin errors++; $display("FAIL alloc_latency: got t+%0d want t+5", fin_cyc - t_edge + 1); end
      checks++; if (cap_replace !== 1'b1 || cap_partial !== 1'b0) begin errors++; $display("FAIL alloc_flags: got replace=%b partial=%b want 1/0", cap_replace, cap_partial); end
      checks++; if (cap_set !== 5'd3 || cap_tag !== 7'h09) begin errors++; $display("FAIL alloc_set_tag: got %h/%h want 03/09", cap_set, cap_tag); end
      checks++; if (cap_dat !== 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0) begin errors++; $display("FAIL alloc_dat: got %h", cap_dat); end
   endtask

   task automatic test_writeback;
      int b = nbeats;
      int f = fin_count;
      logic [31:0] ew [4];
      ew = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      wait_cfg = 2; err_word = -1; stall_word = -1;
      start_req(1'b0, 16'h4560, 16'hFFFF, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      wait_fin(f, "wb", 1'b1);
      wait_cfg = 0;
      checks++; if (nbeats - b != 4) begin errors++; $display("FAIL wb_beats: got %0d want 4", nbeats - b); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (lg_addr[b+k] !== 16'h4560 + 16'(4*k) || lg_we[b+k] !== 1'b1 || lg_wdata[b+k] !== ew[k]) begin
            errors++; $display("FAIL wb_beat%0d: got %h we=%b d=%h want %h we=1 d=%h", k, lg_addr[b+k], lg_we[b+k], lg_wdata[b+k], 16'h4560 + 16'(4*k), ew[k]);
         end
      end
      checks++; if (fin_cyc - t_edge + 1 != 13) begin errors++; $display("FAIL wb_latency: got t+%0d want t+13", fin_cyc - t_edge + 1); end
      checks++; if (cap_replace !== 1'b0) begin errors++; $display("FAIL wb_replace: got %b want 0", cap_replace); end
      checks++; if (cap_dat !== 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0) begin errors++; $display("FAIL wb_dat_hold: got %h", cap_dat); end
   endtask

   task automatic test_commit_merge;
      int f = fin_count;
      rd_words = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
      start_req(1'b1, 16'h0A50, 16'h000F, 128'h11111111_22222222_33333333_DEADBEEF);
      wait_fin(f, "merge_lo", 1'b1);
      checks++; if (cap_dat !== 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_DEADBEEF) begin errors++; $display("FAIL merge_lo_dat: got %h", cap_dat); end
      f = fin_count;
      rd_words = '{32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A};
      start_req(1'b1, 16'hFFF0, 16'h1248, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
      wait_fin(f, "merge_mix", 1'b1);
      checks++; if (cap_dat !== 128'h5A5A5ACC_5A5A995A_5A665A5A_335A5A5A) begin errors++; $display("FAIL merge_mix_dat: got %h", cap_dat); end
      checks++; if (cap_set !== 5'h1F || cap_tag !== 7'h7F) begin errors++; $display("FAIL merge_mix_set_tag: got %h/%h want 1f/7f", cap_set, cap_tag); end
   endtask

   task automatic test_bus_err;
      int b = nbeats;
      int f = fin_count;
      err_word = 1;
      rd_words = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
      start_req(1'b1, 16'h0040, 16'h0000, 128'h0);
      wait_fin(f, "err", 1'b1);
      err_word = -1;
      checks++; if (nbeats - b != 2) begin errors++; $display("FAIL err_beats: got %0d want 2", nbeats - b); end
      checks++; if (fin_cyc - t_edge + 1 != 3) begin errors++; $display("FAIL err_latency: got t+%0d want t+3", fin_cyc - t_edge + 1); end
      checks++; if (cap_replace !== 1'b1 || cap_partial !== 1'b1) begin errors++; $display("FAIL err_flags: got replace=%b partial=%b want 1/1", cap_replace, cap_partial); end
      checks++; if (cap_dat !== 128'h00000000_00000000_00000000_D0D0D0D0) begin errors++; $display("FAIL err_dat: got %h", cap_dat); end
   endtask

   task automatic test_timeout_read;
      int b = nbeats;
      int f = fin_count;
      int r = req_cycles;
      stall_word = 0;
      start_req(1'b1, 16'h2000, 16'h0000, 128'h0);
      wait_fin(f, "tmo_rd", 1'b1);
      stall_word = -1;
      checks++; if (req_cycles - r != TO) begin errors++; $display("FAIL tmo_rd_req_cycles: got %0d want %0d", req_cycles - r, TO); end
      checks++; if (nbeats - b != 0) begin errors++; $display("FAIL tmo_rd_beats: got %0d want 0", nbeats - b); end
      checks++; if (cap_replace !== 1'b1 || cap_partial !== 1'b1) begin errors++; $display("FAIL tmo_rd_flags: got replace=%b partial=%b want 1/1", cap_replace, cap_partial); end
      checks++; if (cap_dat !== 128'h0 || cap_tag !== 7'h10) begin errors++; $display("FAIL tmo_rd_dat: got %h tag %h want 0 tag 10", cap_dat, cap_tag); end
   endtask

   task automatic test_timeout_write;
      int b = nbeats;
      int f = fin_count;
      logic [31:0] ew [4];
      ew = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      stall_word = 0;
      start_req(1'b0, 16'h2000, 16'h0000, 128'h44444444_33333333_22222222_11111111);
      wait_fin(f, "tmo_wr", 1'b1);
      stall_word = -1;
      checks++; if (nbeats - b != 3) begin errors++; $display("FAIL tmo_wr_beats: got %0d want 3", nbeats - b); end
      for (int k = 1; k < 4; k++) begin
         checks++; if (lg_addr[b+k-1] !== 16'h2000 + 16'(4*k) || lg_wdata[b+k-1] !== ew[k]) begin
            errors++; $display("FAIL tmo_wr_beat%0d: got %h d=%h want %h d=%h", k, lg_addr[b+k-1], lg_wdata[b+k-1], 16'h2000 + 16'(4*k), ew[k]);
         end
      end
      checks++; if (fin_cyc - t_edge + 1 != 8) begin errors++; $display("FAIL tmo_wr_latency: got t+%0d want t+8", fin_cyc - t_edge + 1); end
      checks++; if (cap_replace !== 1'b0) begin errors++; $display("FAIL tmo_wr_replace: got %b want 0", cap_replace); end
   endtask

   task automatic test_back_to_back;
      int b = nbeats;
      int f = fin_count;
      start_req(1'b0, 16'h0100, 16'h0000, 128'h1);
      wait_fin(f, "b2b_wr", 1'b0);
      // cache updates its fields during FIN while keeping the request high
      rd_words = '{32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3};
      mem_if.mem_rwn    = 1'b1;
      mem_if.mem_addr   = 16'h0110;
      mem_if.mem_commit = 16'h0000;
      wait_fin(f + 1, "b2b_rd", 1'b1);
      checks++; if (nbeats - b != 8) begin errors++; $display("FAIL b2b_beats: got %0d want 8", nbeats - b); end
      checks++; if (lg_we[b+4] !== 1'b0 || lg_addr[b+4] !== 16'h0110) begin errors++; $display("FAIL b2b_rd_beat0: got %h we=%b want 0110 we=0", lg_addr[b+4], lg_we[b+4]); end
      checks++; if (lg_cyc[b+4] - lg_cyc[b] != 6) begin errors++; $display("FAIL b2b_gap: got %0d want 6", lg_cyc[b+4] - lg_cyc[b]); end
      checks++; if (cap_replace !== 1'b1 || cap_set !== 5'h11 || cap_tag !== 7'h00) begin
         errors++; $display("FAIL b2b_replace: got r=%b set=%h tag=%h want 1/11/00", cap_replace, cap_set, cap_tag);
      end
      checks++; if (cap_dat !== 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0) begin errors++; $display("FAIL b2b_dat: got %h", cap_dat); end
      checks++; if (fin_count - f != 2) begin errors++; $display("FAIL b2b_fin_count: got %0d want 2", fin_count - f); end
   endtask

   task automatic test_reset_mid;
      int f = fin_count;
      wait_cfg = 1;
      start_req(1'b1, 16'h3000, 16'h0000, 128'h0);
      @(posedge sys_clk);
      @(posedge sys_clk);
      #2;
      sys_rst = 1'b0;
      mem_if.mem_request = 1'b0;
      #1;
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_bus_req: got %b want 0", bus_if.bus_req); end
      checks++; if (bus_if.bus_addr !== 16'h0) begin errors++; $display("FAIL rstmid_bus_addr: got %h want 0", bus_if.bus_addr); end
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (8) @(negedge sys_clk);
      wait_cfg = 0;
      checks++; if (fin_count != f) begin errors++; $display("FAIL rstmid_no_finish: got %0d finishes want 0", fin_count - f); end
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle: bus_req got %b want 0", bus_if.bus_req); end
   endtask

   task automatic test_pulses;
      checks++; if (dbl_fin != 0) begin errors++; $display("FAIL pulse_finish: got %0d back-to-back finish cycles want 0", dbl_fin); end
      checks++; if (rep_stray != 0) begin errors++; $display("FAIL pulse_replace: got %0d replace cycles outside FIN want 0", rep_stray); end
   endtask

   initial begin
      mem_if.mem_request    = 1'b0;
      mem_if.mem_rwn        = 1'b0;
      mem_if.mem_addr       = 16'h0;
      mem_if.mem_commit     = 16'h0;
      mem_if.mem_write_data = 128'h0;
      rd_words = '{32'h0, 32'h0, 32'h0, 32'h0};
      test_reset;
      test_alloc_basic;
      test_writeback;
      test_commit_merge;
      test_bus_err;
      test_timeout_read;
      test_timeout_write;
      test_back_to_back;
      test_reset_mid;
      test_pulses;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
